// File: rtl/mha_head_sequencer.sv
// Multi-head attention sequencer: walks NUM_STAGES engines per head over H heads,
// then saturates each head's projection into its column slice of the output buffer.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, abort       run control (start honoured only when idle, abort wins)
//   busy, done         busy level while running, one-cycle done pulse
//   out_valid, error   result-complete level, sticky stage-timeout flag
//   head_idx           head being processed (held after the run)
//   stage_start        one-hot, one-cycle engine start
//   stage_done         engine done flags, only the current stage bit is looked at
//   proj_data          current head's W_O result, row-major (L, E/H)
//   out                final result, row-major (L, E)
//
// Optional build macro ROUND_NEAREST_EN: round half up before the
// projection word is narrowed, instead of plain truncation.
module mha_head_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int ACC_WIDTH      = 32,
    parameter int L              = 8,
    parameter int E              = 8,
    parameter int H              = 2,
    parameter int NUM_STAGES     = 6,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  abort,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  out_valid,
    output logic                                  error,
    output logic [((H > 1) ? $clog2(H) : 1)-1:0]  head_idx,
    output logic [NUM_STAGES-1:0]                 stage_start,
    input  logic [NUM_STAGES-1:0]                 stage_done,
    input  logic [ACC_WIDTH-1:0]                  proj_data [L*(E/H)],
    output logic [DATA_WIDTH-1:0]                 out       [L*E]
);

    localparam int DH = E / H;
    localparam int HW = (H > 1) ? $clog2(H) : 1;
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [HW-1:0] LAST_HEAD  = HW'(H - 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
    localparam logic [TW-1:0] LAST_WAIT  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_STAGES-1:0] FIRST_START = NUM_STAGES'(1);

`ifdef ROUND_NEAREST_EN
    // Half an output LSB, in the sign-extended accumulator domain.
    localparam logic [ACC_WIDTH:0] RND =
        (ACC_WIDTH+1)'(1) << (ACC_WIDTH - DATA_WIDTH - 2);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_WRITEBACK,
        S_DONE
    } state_t;

    state_t          state;
    logic [SW-1:0]   stage;
    logic [TW-1:0]   wait_cnt;

    // Q2.(ACC_WIDTH-2) -> Q1.(DATA_WIDTH-1) with saturation.
    // The word is widened by one sign bit so an optional rounding
    // increment can never wrap; the result is in range only when the
    // top three bits of the widened word agree.
    function automatic logic [DATA_WIDTH-1:0] sat(
        input logic [ACC_WIDTH-1:0] acc
    );
        logic [ACC_WIDTH:0]    s;
        logic [DATA_WIDTH-1:0] r;
`ifdef ROUND_NEAREST_EN
        s = {acc[ACC_WIDTH-1], acc} + RND;
`else
        s = {acc[ACC_WIDTH-1], acc};
`endif
        if ((s[ACC_WIDTH] == s[ACC_WIDTH-1]) &&
            (s[ACC_WIDTH-1] == s[ACC_WIDTH-2])) begin
            r = {s[ACC_WIDTH], s[ACC_WIDTH-3 -: DATA_WIDTH-1]};
        end else if (s[ACC_WIDTH]) begin
            r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            stage       <= '0;
            wait_cnt    <= '0;
            head_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            out_valid   <= 1'b0;
            error       <= 1'b0;
            stage_start <= '0;
            for (int i = 0; i < L*E; i++) begin
                out[i] <= '0;
            end
        end else begin
            // Pulses default low; set only on the cycle entering LAUNCH/DONE.
            done        <= 1'b0;
            stage_start <= '0;

            if (abort && (state != S_IDLE)) begin
                // Partial head slices already written stay in out.
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            head_idx    <= '0;
                            stage       <= '0;
                            error       <= 1'b0;
                            out_valid   <= 1'b0;
                            busy        <= 1'b1;
                            stage_start <= FIRST_START;
                            state       <= S_LAUNCH;
                        end
                    end

                    S_LAUNCH: begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end

                    S_WAIT: begin
                        if (stage_done[stage]) begin
                            if (stage == LAST_STAGE) begin
                                state <= S_WRITEBACK;
                            end else begin
                                stage       <= stage + SW'(1);
                                stage_start <= FIRST_START << (stage + SW'(1));
                                state       <= S_LAUNCH;
                            end
                        end else if (wait_cnt == LAST_WAIT) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + TW'(1);
                        end
                    end

                    S_WRITEBACK: begin
                        // Only the current head's DH-column slice of each row.
                        for (int r = 0; r < L; r++) begin
                            for (int hh = 0; hh < H; hh++) begin
                                if (head_idx == HW'(hh)) begin
                                    for (int c = 0; c < DH; c++) begin
                                        out[r*E + hh*DH + c] <=
                                            sat(proj_data[r*DH + c]);
                                    end
                                end
                            end
                        end
                        if (head_idx == LAST_HEAD) begin
                            done      <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            head_idx    <= head_idx + HW'(1);
                            stage       <= '0;
                            stage_start <= FIRST_START;
                            state       <= S_LAUNCH;
                        end
                    end

                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end

                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mha_head_sequencer.sv
// Scoreboard bench for mha_head_sequencer: engine model, launch and
// result queues, timeout, abort, noise and reset scenarios.
module tb_mha_head_sequencer;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int L  = 8;
    localparam int E  = 8;
    localparam int H  = 2;
    localparam int NS = 6;
    localparam int TO = 16;
    localparam int DH = E / H;

    localparam logic [AW-1:0] SAT0 [4] = '{
        32'h4000_0000, 32'h8000_0000, 32'hBFFF_FFFF, 32'h3FFF_8000
    };
    localparam logic [AW-1:0] SAT1 [4] = '{
        32'h0000_4000, 32'h3FFF_C000, 32'h7FFF_FFFF, 32'hFFFF_8000
    };
`ifdef ROUND_NEAREST_EN
    localparam logic [DW-1:0] HALF_LSB_EXP = 16'h0001;
`else
    localparam logic [DW-1:0] HALF_LSB_EXP = 16'h0000;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done, out_valid, error;
    logic [0:0] head_idx;
    logic [NS-1:0] stage_start;
    logic [NS-1:0] stage_done;
    logic [NS-1:0] eng_done = '0;
    logic [NS-1:0] noise = '0;
    logic [AW-1:0] proj_data [L*DH];
    logic [DW-1:0] out [L*E];

    logic [AW-1:0] proj_tab [H][L*DH];
    logic [DW-1:0] model_out [L*E];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int eng_delay = 3;
    int eng_cnt = 0;
    int eng_idx = 0;
    int block_stage = -1;
    int cur_stage = 0;
    bit noise_en = 1'b0;
    int launch_q [$];
    logic [DW-1:0] out_q [$];

    mha_head_sequencer #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW), .L(L), .E(E), .H(H),
        .NUM_STAGES(NS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .out_valid(out_valid), .error(error),
        .head_idx(head_idx), .stage_start(stage_start),
        .stage_done(stage_done), .proj_data(proj_data), .out(out)
    );

    always #5 clk = ~clk;

    assign stage_done = eng_done | noise;

    always_comb begin
        for (int i = 0; i < L*DH; i++) begin
            proj_data[i] = proj_tab[head_idx][i];
        end
    end

    task automatic check(input string tag, input longint got,
                         input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference narrowing: floor division by 2^15 on a wide signed value,
    // then clamp to the 16-bit signed range.
    function automatic logic [DW-1:0] sat_model(input logic [AW-1:0] acc);
        longint v;
        v = longint'($signed(acc));
`ifdef ROUND_NEAREST_EN
        v = v + 64'sd16384;
`endif
        v = v >>> 15;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return DW'(v);
    endfunction

    task automatic model_head(input int h);
        for (int r = 0; r < L; r++)
            for (int c = 0; c < DH; c++)
                model_out[r*E + h*DH + c] = sat_model(proj_tab[h][r*DH + c]);
    endtask

    task automatic fill_const(input logic [AW-1:0] v0, input logic [AW-1:0] v1);
        for (int i = 0; i < L*DH; i++) begin
            proj_tab[0][i] = v0;
            proj_tab[1][i] = v1;
        end
    endtask

    task automatic fill_sat();
        for (int i = 0; i < L*DH; i++) begin
            proj_tab[0][i] = SAT0[i % 4];
            proj_tab[1][i] = SAT1[i % 4];
        end
    endtask

    task automatic fill_rand();
        for (int h = 0; h < H; h++)
            for (int i = 0; i < L*DH; i++)
                proj_tab[h][i] = $urandom;
    endtask

    // Engine model plus scoreboard consumers, all on the falling edge.
    always @(negedge clk) begin
        int e;
        int idx;
        eng_done = '0;
        noise = '0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0 && eng_idx != block_stage)
                eng_done[eng_idx] = 1'b1;
        end
        if (stage_start != '0) begin
            idx = 0;
            for (int s = 0; s < NS; s++)
                if (stage_start[s]) idx = s;
            if (launch_q.size() == 0) begin
                check("spurious_launch", stage_start, 0);
            end else begin
                e = launch_q.pop_front();
                check("stage_start", stage_start, longint'(1) << (e % 16));
                check("head_idx", head_idx, e / 16);
            end
            eng_idx = idx;
            eng_cnt = eng_delay;
            cur_stage = idx;
        end
        if (noise_en) begin
            noise = NS'($urandom) & ~(NS'(1) << cur_stage);
            noise = noise | stage_start;
        end
        if (done) begin
            done_cnt++;
            check("out_valid_at_done", out_valid, 1);
            if (out_q.size() < L*E) begin
                check("spurious_done", 1, 0);
            end else begin
                for (int i = 0; i < L*E; i++)
                    check("out_word", out[i], out_q.pop_front());
            end
        end
    end

    task automatic push_launches(input int heads, input int last_stage);
        for (int h = 0; h < heads; h++)
            for (int s = 0; s < NS; s++)
                if (h < heads - 1 || s <= last_stage)
                    launch_q.push_back(h*16 + s);
    endtask

    task automatic run_full(input int delay, input bit with_noise,
                            output int lat);
        eng_delay = delay;
        push_launches(H, NS - 1);
        for (int h = 0; h < H; h++) model_head(h);
        for (int i = 0; i < L*E; i++) out_q.push_back(model_out[i]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        noise_en = with_noise;
        check("error_clear_on_start", error, 0);
        check("out_valid_clear_on_start", out_valid, 0);
        lat = 1;
        while (!done && lat < 400) begin
            if (with_noise && lat == 5) start = 1'b1;
            if (lat == 7) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        noise_en = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("launch_q_drained", launch_q.size(), 0);
    endtask

    task automatic wait_launch(input int h, input int s);
        int n;
        n = 0;
        while (!(stage_start[s] && head_idx == 1'(h)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("wait_launch_bound", 0, 1);
    endtask

    initial begin
        int lat;
        int n;
        int dc;

        fill_const('0, '0);
        for (int i = 0; i < L*E; i++) model_out[i] = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_error", error, 0);
        check("rst_head_idx", head_idx, 0);
        check("rst_stage_start", stage_start, 0);
        check("rst_out_first", out[0], 0);
        check("rst_out_last", out[L*E-1], 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal: engines answer 3 cycles after start.
        fill_const(32'h2000_0000, 32'hE000_0000);
        run_full(3, 1'b0, lat);
        check("nominal_latency", lat, 1 + H*(NS*(1+3) + 1));
        check("nominal_col0", out[0], 16'h4000);
        check("nominal_col7", out[L*E-1], 16'hC000);
        check("nominal_head_hold", head_idx, 1);
        repeat (5) @(negedge clk);
        check("out_valid_held", out_valid, 1);
        check("busy_after_done", busy, 0);
        check("nominal_done_count", done_cnt, 1);

        // Saturation and rounding corners, engines answer in first WAIT cycle.
        fill_sat();
        run_full(1, 1'b0, lat);
        check("fast_latency", lat, 1 + H*(2*NS + 1));
        check("sat_pos_ovf", out[0], 16'h7FFF);
        check("sat_min", out[1], 16'h8000);
        check("sat_neg_ovf", out[2], 16'h8000);
        check("sat_pos_edge", out[3], 16'h7FFF);
        check("half_lsb", out[4], HALF_LSB_EXP);
        check("round_edge", out[5], 16'h7FFF);
        check("sat_max", out[6], 16'h7FFF);
        check("neg_small", out[7], 16'hFFFF);

        // Timeout: stage 2 of head 0 never answers.
        dc = done_cnt;
        eng_delay = 3;
        block_stage = 2;
        push_launches(1, 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_launch(0, 2);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, TO + 1);
        check("timeout_error", error, 1);
        check("timeout_out_valid", out_valid, 0);
        check("timeout_launch_q", launch_q.size(), 0);
        repeat (3) @(negedge clk);
        check("timeout_no_done", done_cnt, dc);
        check("error_sticky", error, 1);
        block_stage = -1;

        // Next start clears the error; random projections.
        fill_rand();
        run_full(2, 1'b0, lat);
        check("rand_latency", lat, 1 + H*(NS*(1+2) + 1));
        check("rand_error", error, 0);

        // Abort coinciding with stage_done[3] of head 1.
        dc = done_cnt;
        fill_rand();
        model_head(0);
        eng_delay = 3;
        push_launches(2, 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_launch(1, 3);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", busy, 0);
        repeat (8) @(negedge clk);
        check("abort_no_done", done_cnt, dc);
        check("abort_out_valid", out_valid, 0);
        check("abort_error", error, 0);
        check("abort_head_hold", head_idx, 1);
        check("abort_launch_q", launch_q.size(), 0);
        for (int i = 0; i < L*E; i++)
            check("abort_out_word", out[i], model_out[i]);

        // Noise: stray done bits, done during LAUNCH, start while busy.
        fill_rand();
        run_full(1, 1'b1, lat);
        check("noise_latency", lat, 1 + H*(2*NS + 1));
        check("noise_done_count", done_cnt, dc + 1);

        // Reset in the middle of a run.
        launch_q.push_back(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_stage_start", stage_start, 0);
        check("midrst_out", out[0], 0);
        launch_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
